capture_ctrl: RTL

//  Capture sequencer in the core_clk domain, upstream of the sample-to-memory path.

---
 rtl/capture_pkg.sv | 14 +
 rtl/capture_ctrl_if.sv | 10 +
 rtl/capture_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared state encodings for the capture sequencer.
package capture_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sampler-side handshake of the capture sequencer: sample/trigger in, enable/write strobe out.
interface capture_ctrl_if;
  logic sample_valid;
  logic trig_hit;
  logic sample_en;
  logic capture_valid;

  modport master (input sample_valid, trig_hit, output sample_en, capture_valid);
  modport slave  (output sample_valid, trig_hit, input sample_en, capture_valid);
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger depth, arm on trigger, post-trigger depth, done/abort reporting.
// Optional auto-trigger timeout in WAIT is built when CAPTURE_CTRL_TIMEOUT_EN is defined.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TO_W  = 32
) (
  input  logic                core_clk,
  input  logic                core_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    pre_depth,
  input  logic [CNT_W-1:0]    total_depth,
  input  logic [TO_W-1:0]     timeout_cyc,
  capture_ctrl_if.master      smp,
  output logic                busy,
  output logic                trig_seen,
  output logic [CNT_W-1:0]    trig_pos,
  output logic [CNT_W-1:0]    sample_count,
  output logic                capture_done,
  output logic                aborted,
  output logic [STATE_W-1:0]  state
);

  state_t             state_reg;
  logic               start_1t_reg;
  logic [CNT_W-1:0]   pre_eff_reg;
  logic [CNT_W-1:0]   post_left_reg;
  logic [CNT_W-1:0]   sample_count_reg;
  logic [CNT_W-1:0]   trig_pos_reg;
  logic               trig_seen_reg;
  logic               sample_en_reg;
  logic               capture_done_reg;
  logic               aborted_reg;

  logic               counting;
  logic               start_rise;
  logic               sample_hit;
  logic               force_trig;
  logic [CNT_W-1:0]   pre_eff_calc;
  logic [CNT_W-1:0]   count_inc;

`ifdef CAPTURE_CTRL_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_reg;
  assign force_trig = (timeout_cyc != '0) && (to_cnt_reg >= timeout_cyc);
`else
  logic               unused_timeout;
  assign unused_timeout = ^timeout_cyc;
  assign force_trig     = 1'b0;
`endif

  assign counting     = (state_reg == ST_PRE) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
  assign start_rise   = start & ~start_1t_reg;
  // abort wins over a sample in the same cycle, so the write strobe is suppressed too
  assign sample_hit   = smp.sample_valid & counting & ~abort;
  assign pre_eff_calc = (pre_depth < total_depth) ? pre_depth : total_depth;
  assign count_inc    = sample_count_reg + CNT_W'(1);

  assign smp.sample_en     = sample_en_reg;
  assign smp.capture_valid = sample_hit;
  assign busy              = (state_reg != ST_IDLE);
  assign trig_seen         = trig_seen_reg;
  assign trig_pos          = trig_pos_reg;
  assign sample_count      = sample_count_reg;
  assign capture_done      = capture_done_reg;
  assign aborted           = aborted_reg;
  assign state             = state_reg;

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      state_reg        <= ST_IDLE;
      start_1t_reg     <= 1'b0;
      pre_eff_reg      <= '0;
      post_left_reg    <= '0;
      sample_count_reg <= '0;
      trig_pos_reg     <= '0;
      trig_seen_reg    <= 1'b0;
      sample_en_reg    <= 1'b0;
      capture_done_reg <= 1'b0;
      aborted_reg      <= 1'b0;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
      to_cnt_reg       <= '0;
`endif
    end else begin
      start_1t_reg     <= start;
      capture_done_reg <= 1'b0;
      aborted_reg      <= 1'b0;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
      if (state_reg != ST_WAIT)
        to_cnt_reg <= '0;
      else if (to_cnt_reg < timeout_cyc)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
`endif
      if (counting && abort) begin
        state_reg     <= ST_IDLE;
        sample_en_reg <= 1'b0;
        aborted_reg   <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_rise) begin
              pre_eff_reg      <= pre_eff_calc;
              post_left_reg    <= total_depth - pre_eff_calc;
              sample_count_reg <= '0;
              trig_pos_reg     <= '0;
              trig_seen_reg    <= 1'b0;
              if (total_depth == '0) begin
                state_reg        <= ST_DONE;
                capture_done_reg <= 1'b1;
              end else if (pre_eff_calc == '0) begin
                state_reg     <= ST_WAIT;
                sample_en_reg <= 1'b1;
              end else begin
                state_reg     <= ST_PRE;
                sample_en_reg <= 1'b1;
              end
            end
          end
          ST_PRE: begin
            if (sample_hit) begin
              sample_count_reg <= count_inc;
              if (count_inc == pre_eff_reg) begin
                // pre depth may swallow the whole capture, leaving nothing to trigger for
                if (post_left_reg == '0) begin
                  state_reg        <= ST_DONE;
                  sample_en_reg    <= 1'b0;
                  capture_done_reg <= 1'b1;
                end else begin
                  state_reg <= ST_WAIT;
                end
              end
            end
          end
          ST_WAIT: begin
            if (sample_hit) begin
              sample_count_reg <= count_inc;
              if (smp.trig_hit || force_trig) begin
                trig_pos_reg  <= sample_count_reg;
                trig_seen_reg <= 1'b1;
                post_left_reg <= post_left_reg - CNT_W'(1);
                if (post_left_reg == CNT_W'(1)) begin
                  state_reg        <= ST_DONE;
                  sample_en_reg    <= 1'b0;
                  capture_done_reg <= 1'b1;
                end else begin
                  state_reg <= ST_POST;
                end
              end
            end
          end
          ST_POST: begin
            if (sample_hit) begin
              sample_count_reg <= count_inc;
              post_left_reg    <= post_left_reg - CNT_W'(1);
              if (post_left_reg == CNT_W'(1)) begin
                state_reg        <= ST_DONE;
                sample_en_reg    <= 1'b0;
                capture_done_reg <= 1'b1;
              end
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: begin
            state_reg     <= ST_IDLE;
            sample_en_reg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
